// File: rtl/sprite_scaler.sv
// sprite_scaler: 3-stage pipelined scaled indexed-colour sprite renderer with incremental ROM addressing.
// Optional transparency via `define SPRITE_SCALER_TRANSP_EN.
module sprite_scaler #(
  parameter int SPR_W = 50,
  parameter int SPR_H = 50,
  parameter int ADDR_BITS = 12,
  parameter int IDX_BITS = 2,
  parameter int SCALE_BITS = 3,
  parameter int TRANSP_IDX = 0
) (
  input  logic                  vga_clk,
  input  logic                  rst_n,
  input  logic [9:0]            DrawX,
  input  logic [9:0]            DrawY,
  input  logic                  blank,
  input  logic [9:0]            pos_x,
  input  logic [9:0]            pos_y,
  input  logic [SCALE_BITS-1:0] scale,
  input  logic                  sprite_en,
  input  logic [11:0]           bg_rgb,
  output logic [ADDR_BITS-1:0]  rom_addr,
  input  logic [IDX_BITS-1:0]   rom_q,
  output logic [IDX_BITS-1:0]   pal_index,
  input  logic [11:0]           pal_rgb,
  output logic [3:0]            red,
  output logic [3:0]            green,
  output logic [3:0]            blue
);
  localparam int CW = $clog2(SPR_W + 1);
  localparam int RW = $clog2(SPR_H + 1);
  localparam int SB = SCALE_BITS;
`ifdef SPRITE_SCALER_TRANSP_EN
  localparam bit TRANSP_EN = 1'b1;
`else
  localparam bit TRANSP_EN = 1'b0;
`endif
  logic [9:0] pos_x_l, pos_y_l, px, py;
  logic [SB-1:0] scale_l, sc, sy_q, sy_c, sx_q, sx_c, sx_n;
  logic en_l, en, fs, ls, v_q, v_c, h_q, h_c, h_n, at_x, wrap_x, hit;
  logic [RW-1:0] row_q, row_c;
  logic [CW-1:0] col_q, col_c, col_n;
  logic [ADDR_BITS-1:0] rb_q, rb_c;
  logic hit1, blank1, hit2, blank2, use_pal;
  logic [11:0] bg1, bg2, rgb;
  assign fs = DrawX == 10'd0 && DrawY == 10'd0;
  assign ls = DrawX == 10'd0;
  // frame-start values take effect in the same cycle they are latched
  assign px = fs ? pos_x : pos_x_l;
  assign py = fs ? pos_y : pos_y_l;
  assign sc = fs ? (scale == '0 ? SB'(1) : scale) : scale_l;
  assign en = fs ? sprite_en : en_l;
  always_comb begin
    v_c = v_q;
    row_c = row_q;
    sy_c = sy_q;
    rb_c = rb_q;
    if (ls) begin
      if (DrawY == py) begin
        v_c = 1'b1;
        row_c = '0;
        sy_c = '0;
        rb_c = '0;
      end else if (v_q && !fs) begin
        if (sy_q == sc - SB'(1)) begin
          sy_c = '0;
          row_c = row_q + RW'(1);
          rb_c = rb_q + ADDR_BITS'(SPR_W);
          v_c = row_q + RW'(1) != RW'(SPR_H);
        end else sy_c = sy_q + SB'(1);
      end else v_c = 1'b0;
    end
  end
  assign at_x = DrawX == px;
  assign h_c = at_x || (!ls && h_q);
  assign col_c = at_x ? '0 : col_q;
  assign sx_c = at_x ? '0 : sx_q;
  assign wrap_x = sx_c == sc - SB'(1);
  assign sx_n = wrap_x ? '0 : sx_c + SB'(1);
  assign col_n = wrap_x ? col_c + CW'(1) : col_c;
  assign h_n = h_c && !(wrap_x && col_c + CW'(1) == CW'(SPR_W));
  assign hit = en && v_c && h_c;
  assign use_pal = hit2 && !(TRANSP_EN && rom_q == IDX_BITS'(TRANSP_IDX));
  assign pal_index = rom_q;
  assign {red, green, blue} = rgb;
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      {pos_x_l, pos_y_l, scale_l, en_l} <= '0;
      {v_q, row_q, sy_q, rb_q, h_q, col_q, sx_q} <= '0;
      {hit1, blank1, bg1, hit2, blank2, bg2} <= '0;
      rom_addr <= '0;
      rgb <= '0;
    end else begin
      if (fs) begin
        pos_x_l <= pos_x;
        pos_y_l <= pos_y;
        scale_l <= sc;
        en_l <= sprite_en;
      end
      {v_q, row_q, sy_q, rb_q} <= {v_c, row_c, sy_c, rb_c};
      {h_q, col_q, sx_q} <= {h_n, col_n, sx_n};
      hit1 <= hit;
      blank1 <= blank;
      bg1 <= bg_rgb;
      if (hit) rom_addr <= rb_c + ADDR_BITS'(col_c);
      hit2 <= hit1;
      blank2 <= blank1;
      bg2 <= bg1;
      rgb <= !blank2 ? 12'h000 : use_pal ? pal_rgb : bg2;
    end
  end
endmodule

// File: doc/sprite_scaler.md
# sprite_scaler

Parametrised, fully pipelined indexed-colour sprite renderer for the VGA path. It places one SPR_W x SPR_H sprite at a per-frame position with an integer scale factor, and generates ROM addresses with incremental counters instead of multiply/divide. It sits between the VGA controller (DrawX/DrawY/blank) and the colour output, in front of an external synchronous sprite ROM and a combinational palette. Outside the sprite, and on the transparent index, it passes through a background colour.

## Interface
- SPR_W, 50, sprite width in texels
- SPR_H, 50, sprite height in texels
- ADDR_BITS, 12, ROM address width; must satisfy SPR_W*SPR_H <= 2^ADDR_BITS
- IDX_BITS, 2, palette index width
- SCALE_BITS, 3, scale input width; usable scales are 1..2^SCALE_BITS-1
- TRANSP_IDX, 0, palette index treated as transparent
- vga_clk  in  1  pixel clock; all state on posedge
- rst_n  in  1  asynchronous active-low reset
- DrawX, DrawY  in  10 each  current pixel coordinate from the VGA controller
- blank  in  1  high = visible display region
- pos_x, pos_y  in  10 each  sprite top-left; sampled at frame start
- scale  in  SCALE_BITS  texel magnification; 0 is treated as 1; sampled at frame start
- sprite_en  in  1  draw enable; sampled at frame start
- bg_rgb  in  12  background colour {R,G,B} for the current DrawX/DrawY
- rom_addr  out  ADDR_BITS  registered address to the sprite ROM
- rom_q  in  IDX_BITS  ROM data; valid 1 cycle after rom_addr
- pal_index  out  IDX_BITS  equals rom_q; drives the palette
- pal_rgb  in  12  combinational palette result for pal_index
- red, green, blue  out  4 each  registered pixel colour

## Operation
- Frame start is the cycle where DrawX==0 && DrawY==0. On that cycle, pos_x, pos_y, max(scale,1) and sprite_en are latched. Input changes at any other time have no effect until the next frame start.
- Line start is any cycle where DrawX==0. Vertical state updates only at line start:
  - If DrawY==pos_y_l: v_active=1, row=0, sub_y=0, row_base=0.
  - Else if v_active: sub_y increments. When sub_y reaches scale_l-1, sub_y wraps to 0, row increments and row_base += SPR_W.
  - When row reaches SPR_H, v_active=0.
- Horizontal state:
  - At DrawX==pos_x_l: h_active=1, col=0, sub_x=0.
  - Each following pixel: sub_x increments. On wrap at scale_l-1, col increments.
  - When col reaches SPR_W, h_active=0. h_active also clears at line start.
- hit = sprite_en_l && v_active && h_active for the current pixel. The issued address is row_base + col, which equals floor((DrawY-pos_y)/scale)*SPR_W + floor((DrawX-pos_x)/scale).
- Width rules: row_base and the address are ADDR_BITS wide, and the address never exceeds SPR_W*SPR_H-1. col and row counters are sized to hold SPR_W and SPR_H. No multipliers or dividers are allowed in the datapath.
- Colour select:
  - blank low: output 0.
  - Else if hit: output pal_rgb.
  - Else: output bg_rgb.
  - The transparency rule is in Configuration.
- Clipping: sprite pixels with DrawX>=640 or DrawY>=480 are simply never shown. Counters run on the real DrawX/DrawY, so horizontal wrap-around cannot occur. If pos_x_l>=640 or pos_y_l>=480, the sprite is never drawn.
- When hit=0, rom_addr holds its previous value.

## Timing
- Stage 1: hit, rom_addr, blank and bg_rgb are registered.
- Stage 2: rom_q becomes valid; hit, blank and bg_rgb are delayed one more cycle.
- Stage 3: red/green/blue are registered.
- Total latency is 3 cycles from DrawX/DrawY to red/green/blue. The upstream controller must advance coordinates by 3 pixels or accept a 3-pixel shift.
- Throughput is one pixel per cycle with no stalls.
- Reset (asynchronous, at any point including mid-frame):
  - red/green/blue=0, rom_addr=0; all pipeline valid/hit bits, counters and latches clear.
  - Latched sprite_en=0, so nothing is drawn until the first frame start after reset release.
- Simultaneous events: frame start together with DrawY==pos_y (pos_y=0) uses the newly latched values in the same cycle. Frame start also counts as a line start.

## Configuration
- SPRITE_SCALER_TRANSP_EN defined: a stage-3 hit whose rom_q==TRANSP_IDX outputs the delayed bg_rgb instead of pal_rgb.
- SPRITE_SCALER_TRANSP_EN not defined: every index, including TRANSP_IDX, outputs pal_rgb. The TRANSP_IDX parameter is unused.

## Test plan
- Reset: assert rst_n low at DrawX=300, DrawY=200 while drawing -> red/green/blue=0 and rom_addr=0 immediately. After release, nothing is drawn until DrawX=0, DrawY=0.
- Scale 1, pos (100,50), blank=1:
  - DrawX=100, DrawY=50 -> rom_addr=0 one cycle later, rgb=pal_rgb three cycles later.
  - DrawX=149 -> rom_addr=49.
  - DrawX=150 -> bg_rgb.
  - DrawY=51, DrawX=100 -> rom_addr=50.
- Scale 4, pos (0,0):
  - DrawX 0..3 -> addr 0; DrawX=4 -> addr 1.
  - DrawY=4, DrawX=0 -> addr 50.
  - DrawX=199, DrawY=199 -> addr 2499.
  - DrawY=200 -> bg_rgb.
- scale=0 at frame start -> behaves identically to scale 1.
- Change pos_x from 100 to 300 at DrawY=10 -> the rest of the frame still draws at 100; the next frame draws at 300.
- Transparency, with pos (620,0), scale 1, rom_q=0, TRANSP_IDX=0:
  - Macro defined -> bg_rgb; macro undefined -> pal_rgb.
  - DrawX 620..639 -> addr 0..19; nothing drawn past 639.
